makerdemo_gpio_fade: RTL and testbench
======================================

// Module: makerdemo_gpio_fade
// PURPOSE
//  Fabric consumer of the MSS GPIO_x_M2F outputs. Synchronises N_CH GPIO levels into the
//  CLK_BASE domain and drives one PWM LED per channel, fading up or down on each GPIO change.
//  Gated by MSS_READY from the reset controller. Runs a lamp test (all LEDs fully on) after
//  every MSS_READY rise. Sits directly downstream of the MSS/CoreResetP subsystem, on the CCC GL0 clock.
// PARAMETERS
//  N_CH         8     number of GPIO/LED channels
//  PWM_BITS     8     duty/counter width; MAX = 2**PWM_BITS-1
//  STEP_DIV     1024  CLK_BASE cycles per fade step (>=2)
//  LAMP_CYCLES  4096  CLK_BASE cycles LEDs are held fully on in lamp test (>=1)
// PORTS
//  CLK_BASE    in   1     fabric clock (CCC GL0)
//  RESET_N     in   1     async active-low reset
//  MSS_READY   in   1     MSS ready level from reset controller (async, 2FF-synced here)
//  GPIO_M2F    in   N_CH  MSS GPIO levels, bit i = GPIO_i_M2F (async, 2FF-synced here)
//  LED         out  N_CH  registered PWM outputs
//  ACTIVE      out  1     high while in RUN
//  LAMP_TEST   out  1     high while in LAMP
// BEHAVIOUR
//  Interface: one clock; reset is asynchronous and active-low.
//  Reset: LED=0, ACTIVE=0, LAMP_TEST=0, state=WAIT, all duties/counters/sync flops 0.
//  Sync: rdy_s and gpio_s are 2FF outputs; 2-cycle latency from input to rdy_s/gpio_s.
//  pwm_cnt: free-running, counts 0..MAX-1, then wraps to 0 (period MAX clocks).
//   LED[i] <= (state!=WAIT) && (pwm_cnt < duty[i]) ; registered, 1-cycle latency.
//   duty 0 -> always off; duty MAX -> always on.
//  Prescaler: counts 0..STEP_DIV-1; tick=1 on the cycle it equals STEP_DIV-1, then wraps.
//   Cleared to 0 on every state entry.
//  FSM:
//   WAIT: duties=0. rdy_s=1 -> LAMP; lamp_cnt=0, all duties=MAX.
//   LAMP: LAMP_TEST=1. lamp_cnt increments every clock.
//    lamp_cnt==LAMP_CYCLES-1 -> RUN, all duties loaded to 0.
//   RUN: ACTIVE=1. On tick, per channel: target = gpio_s[i] ? MAX : 0.
//    duty < target -> +1; duty > target -> -1; equal -> hold.
//    Saturating; never overshoots or wraps. Full 0<->MAX fade = MAX ticks.
//   Any state, rdy_s=0 -> WAIT next cycle. Duties cleared; LED=0 from the following cycle.
//   rdy_s priority over the lamp/tick transitions.
//  GPIO change mid-fade: direction reverses on the next tick from the current duty; no jump.
//  GPIO changes during WAIT/LAMP are ignored until RUN; RUN starts each channel from 0.
//  Simultaneous tick and GPIO change: the tick uses the gpio_s value present that cycle.
//  RESET_N assertion mid-operation: all outputs 0 immediately (async), no clock required.
// TESTING (sim params: PWM_BITS=4 -> MAX=15, STEP_DIV=4, LAMP_CYCLES=16, N_CH=8)
//  1 Reset, MSS_READY=0, GPIO_M2F=8'hFF for 500 cycles -> LED=0, ACTIVE=0, LAMP_TEST=0 throughout.
//  2 MSS_READY 0->1 -> LAMP_TEST=1 after 3 clocks for exactly 16 clocks, LED=8'hFF solid
//    (1 clk later); then ACTIVE=1, LED=8'h00.
//  3 RUN, GPIO_M2F=8'h01 -> duty[0] +1 every 4 clocks, reaches 15 after 60 clocks and holds.
//    Each 15-clock period has LED[0] high for exactly duty[0] clocks; LED[7:1]=0.
//  4 GPIO_M2F 8'h01->8'h00 at duty[0]=7 -> duty steps 7,6..0 every 4 clocks, stays 0, LED[0]=0.
//    Repeat with toggle back at duty 3 -> resumes rising from 3.
//  5 MSS_READY 1->0 in RUN mid-fade -> ACTIVE=0 and LED=0 within 4 clocks.
//    Re-assert -> full 16-clock lamp test repeats, then fades restart from 0.
//  6 RESET_N low asynchronously (between clock edges) mid-fade, LEDs on -> all outputs 0 before
//    next edge; release -> WAIT behaviour as scenario 1.

Source files
------------

// File: rtl/makerdemo_gpio_fade.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : makerdemo_gpio_fade
// Description : Fabric consumer of the MSS GPIO_x_M2F outputs. Synchronises
//               N_CH GPIO levels into the CLK_BASE domain and drives one PWM
//               LED per channel, fading up or down whenever a GPIO changes.
//               Gated by MSS_READY; every MSS_READY rise first runs a lamp
//               test that holds all LEDs fully on for LAMP_CYCLES clocks.
// Ports       : CLK_BASE  in   fabric clock (CCC GL0)
//               RESET_N   in   asynchronous active-low reset
//               MSS_READY in   MSS ready level (async, 2FF-synchronised here)
//               GPIO_M2F  in   N_CH GPIO levels (async, 2FF-synchronised here)
//               LED       out  N_CH registered PWM outputs
//               ACTIVE    out  high while in RUN
//               LAMP_TEST out  high while in LAMP
// Revision    : 1.0 - initial release
// ============================================================================
module makerdemo_gpio_fade #(
    parameter int N_CH        = 8,
    parameter int PWM_BITS    = 8,
    parameter int STEP_DIV    = 1024,
    parameter int LAMP_CYCLES = 4096
) (
    input  logic            CLK_BASE,
    input  logic            RESET_N,
    input  logic            MSS_READY,
    input  logic [N_CH-1:0] GPIO_M2F,
    output logic [N_CH-1:0] LED,
    output logic            ACTIVE,
    output logic            LAMP_TEST
);

    localparam int STEP_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam int LAMP_W = (LAMP_CYCLES > 1) ? $clog2(LAMP_CYCLES) : 1;

    localparam logic [PWM_BITS-1:0] DUTY_MAX  = {PWM_BITS{1'b1}};
    localparam logic [PWM_BITS-1:0] DUTY_ONE  = PWM_BITS'(1);
    // The counter stops one short of MAX so that duty==MAX is always on.
    localparam logic [PWM_BITS-1:0] PWM_LAST  = DUTY_MAX - DUTY_ONE;
    localparam logic [STEP_W-1:0]   STEP_LAST = STEP_W'(STEP_DIV - 1);
    localparam logic [LAMP_W-1:0]   LAMP_LAST = LAMP_W'(LAMP_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_WAIT = 2'd0,
        ST_LAMP = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    state_t              state;
    logic                rdy_meta;
    logic                rdy_s;
    logic [N_CH-1:0]     gpio_meta;
    logic [N_CH-1:0]     gpio_s;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic [STEP_W-1:0]   presc;
    logic [LAMP_W-1:0]   lamp_cnt;
    logic [PWM_BITS-1:0] duty [N_CH];
    logic                tick;

    assign tick = (presc == STEP_LAST);

    // Two-flop synchronisers for the asynchronous MSS-side levels.
    always_ff @(posedge CLK_BASE or negedge RESET_N) begin
        if (!RESET_N) begin
            rdy_meta  <= 1'b0;
            rdy_s     <= 1'b0;
            gpio_meta <= '0;
            gpio_s    <= '0;
        end else begin
            rdy_meta  <= MSS_READY;
            rdy_s     <= rdy_meta;
            gpio_meta <= GPIO_M2F;
            gpio_s    <= gpio_meta;
        end
    end

    // Free-running PWM phase counter, period MAX clocks.
    always_ff @(posedge CLK_BASE or negedge RESET_N) begin
        if (!RESET_N) begin
            pwm_cnt <= '0;
        end else if (pwm_cnt == PWM_LAST) begin
            pwm_cnt <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + DUTY_ONE;
        end
    end

    // Control FSM, fade prescaler, lamp timer, duty registers and outputs.
    always_ff @(posedge CLK_BASE or negedge RESET_N) begin
        if (!RESET_N) begin
            state     <= ST_WAIT;
            presc     <= '0;
            lamp_cnt  <= '0;
            LED       <= '0;
            ACTIVE    <= 1'b0;
            LAMP_TEST <= 1'b0;
            for (int i = 0; i < N_CH; i++) begin
                duty[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                LED[i] <= (state != ST_WAIT) && (pwm_cnt < duty[i]);
            end

            presc <= tick ? '0 : presc + STEP_W'(1);

            // Losing MSS_READY overrides every other transition.
            if (!rdy_s) begin
                state     <= ST_WAIT;
                ACTIVE    <= 1'b0;
                LAMP_TEST <= 1'b0;
                if (state != ST_WAIT) begin
                    presc <= '0;
                end
                for (int i = 0; i < N_CH; i++) begin
                    duty[i] <= '0;
                end
            end else begin
                case (state)
                    ST_WAIT: begin
                        state     <= ST_LAMP;
                        lamp_cnt  <= '0;
                        LAMP_TEST <= 1'b1;
                        presc     <= '0;
                        for (int i = 0; i < N_CH; i++) begin
                            duty[i] <= DUTY_MAX;
                        end
                    end
                    ST_LAMP: begin
                        lamp_cnt <= lamp_cnt + LAMP_W'(1);
                        if (lamp_cnt == LAMP_LAST) begin
                            state     <= ST_RUN;
                            LAMP_TEST <= 1'b0;
                            ACTIVE    <= 1'b1;
                            presc     <= '0;
                            for (int i = 0; i < N_CH; i++) begin
                                duty[i] <= '0;
                            end
                        end
                    end
                    ST_RUN: begin
                        // One saturating step toward each channel's target.
                        if (tick) begin
                            for (int i = 0; i < N_CH; i++) begin
                                if (gpio_s[i] && (duty[i] != DUTY_MAX)) begin
                                    duty[i] <= duty[i] + DUTY_ONE;
                                end else if (!gpio_s[i] && (duty[i] != '0)) begin
                                    duty[i] <= duty[i] - DUTY_ONE;
                                end
                            end
                        end
                    end
                    default: begin
                        state     <= ST_WAIT;
                        ACTIVE    <= 1'b0;
                        LAMP_TEST <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_makerdemo_gpio_fade.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_makerdemo_gpio_fade
// Description : Scoreboard bench for makerdemo_gpio_fade (MAX=15, STEP_DIV=4,
//               LAMP_CYCLES=16). Stimulus pushes time-stamped expectations;
//               a monitor pops and compares them on the falling clock edge,
//               or immediately for the asynchronous-reset check.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_makerdemo_gpio_fade;

    logic       CLK_BASE;
    logic       RESET_N;
    logic       MSS_READY;
    logic [7:0] GPIO_M2F;
    logic [7:0] LED;
    logic       ACTIVE;
    logic       LAMP_TEST;

    makerdemo_gpio_fade #(
        .N_CH        (8),
        .PWM_BITS    (4),
        .STEP_DIV    (4),
        .LAMP_CYCLES (16)
    ) dut (
        .CLK_BASE  (CLK_BASE),
        .RESET_N   (RESET_N),
        .MSS_READY (MSS_READY),
        .GPIO_M2F  (GPIO_M2F),
        .LED       (LED),
        .ACTIVE    (ACTIVE),
        .LAMP_TEST (LAMP_TEST)
    );

    typedef struct {
        int         cyc;   // -1: check immediately on async_ev
        logic [9:0] exp;   // {LED, ACTIVE, LAMP_TEST}
        string      name;
    } exp_t;

    exp_t       sb[$];
    event       async_ev;
    int         cyc = 0;
    int         c0  = 0;     // cycle count at the last reset release
    int         cr  = 0;     // edge on which RUN was entered
    int         exp_duty[8];
    logic [7:0] gpio_lvl;
    int         total = 0;
    int         bad   = 0;

    initial begin
        CLK_BASE = 1'b0;
        forever #5 CLK_BASE = ~CLK_BASE;
    end

    always @(posedge CLK_BASE) cyc <= cyc + 1;

    task automatic tick();
        @(posedge CLK_BASE);
        #1;
    endtask

    task automatic expect_now(input logic [7:0] led, input logic act,
                              input logic lamp, input string nm);
        exp_t e;
        e.cyc  = cyc;
        e.exp  = {led, act, lamp};
        e.name = nm;
        sb.push_back(e);
    endtask

    task automatic set_gpio(input logic [7:0] v);
        gpio_lvl = v;
        GPIO_M2F = v;
    endtask

    // PWM counter value after edge c: it restarts at 0 on reset release.
    function automatic int pwm_after(input int c);
        return (c - c0) % 15;
    endfunction

    // Expected outputs for one RUN cycle. LED uses the duty held before this
    // edge; fade steps land on edges cr+4, cr+8, ... GPIO is only changed
    // right after a step edge, so the synchronised level is settled by the
    // next step.
    task automatic run_cycle(input string nm);
        logic [7:0] led;
        int c;
        c = cyc;
        for (int i = 0; i < 8; i++) led[i] = (pwm_after(c - 1) < exp_duty[i]);
        if (((c - cr) % 4) == 0) begin
            for (int i = 0; i < 8; i++) begin
                if (gpio_lvl[i] && exp_duty[i] < 15) exp_duty[i]++;
                else if (!gpio_lvl[i] && exp_duty[i] > 0) exp_duty[i]--;
            end
        end
        expect_now(led, 1'b1, 1'b0, nm);
    endtask

    task automatic run_n(input int n, input string nm);
        repeat (n) begin
            tick();
            run_cycle(nm);
        end
    endtask

    // MSS_READY rise: 2 sync clocks, LAMP on the 3rd edge for 16 clocks,
    // LEDs solid one clock after LAMP entry, RUN on the 19th edge.
    task automatic lamp_seq(input logic [7:0] g);
        MSS_READY = 1'b1;
        for (int k = 1; k <= 19; k++) begin
            tick();
            if (k <= 2)       expect_now(8'h00, 1'b0, 1'b0, "lamp_sync");
            else if (k <= 18) expect_now((k >= 4) ? 8'hFF : 8'h00, 1'b0, 1'b1, "lamp_on");
            else              expect_now(8'hFF, 1'b1, 1'b0, "lamp_exit");
            if (k == 10) set_gpio(g);
        end
        cr = cyc;
        for (int i = 0; i < 8; i++) exp_duty[i] = 0;
    endtask

    // Monitor / scoreboard checker.
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK_BASE or async_ev);
            while (sb.size() > 0 && (sb[0].cyc == -1 || sb[0].cyc <= cyc)) begin
                e = sb.pop_front();
                total++;
                if (e.cyc != -1 && e.cyc < cyc) begin
                    bad++;
                    $display("FAIL %s: expectation for cycle %0d not checked in time (now %0d)",
                             e.name, e.cyc, cyc);
                end else if ({LED, ACTIVE, LAMP_TEST} !== e.exp) begin
                    bad++;
                    $display("FAIL %s cyc=%0d: got led=%h active=%b lamp=%b, required led=%h active=%b lamp=%b",
                             e.name, e.cyc, LED, ACTIVE, LAMP_TEST,
                             e.exp[9:2], e.exp[1], e.exp[0]);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        exp_t e;
        logic [7:0] led;
        RESET_N   = 1'b1;
        MSS_READY = 1'b0;
        set_gpio(8'hFF);
        for (int i = 0; i < 8; i++) exp_duty[i] = 0;
        #2 RESET_N = 1'b0;

        // Reset and idle WAIT with GPIO high and MSS_READY low.
        repeat (3) begin
            tick();
            expect_now(8'h00, 1'b0, 1'b0, "reset_state");
        end
        c0 = cyc;
        RESET_N = 1'b1;
        repeat (500) begin
            tick();
            expect_now(8'h00, 1'b0, 1'b0, "wait_idle");
        end

        // Lamp test, then channel 0 fades up from 0 and holds at MAX.
        lamp_seq(8'h01);
        run_n(64, "fade_up");
        // Full fade down to 0 and hold.
        set_gpio(8'h00);
        run_n(68, "fade_down");
        // Rise to 7, reverse to 3, reverse again up to 8.
        set_gpio(8'h01);
        run_n(28, "rise_to_7");
        set_gpio(8'h00);
        run_n(16, "fall_to_3");
        set_gpio(8'h01);
        run_n(20, "resume_rise");

        // MSS_READY drop mid-fade: WAIT on the 3rd edge, LEDs dark on the 4th.
        MSS_READY = 1'b0;
        repeat (2) begin
            tick();
            run_cycle("ready_drop_run");
        end
        tick();
        for (int i = 0; i < 8; i++) led[i] = (pwm_after(cyc - 1) < exp_duty[i]);
        expect_now(led, 1'b0, 1'b0, "ready_drop_wait");
        for (int i = 0; i < 8; i++) exp_duty[i] = 0;
        set_gpio(8'hFF);
        repeat (20) begin
            tick();
            expect_now(8'h00, 1'b0, 1'b0, "wait_again");
        end

        // Re-assert: lamp test repeats, all channels fade from 0 to full.
        lamp_seq(8'hFF);
        run_n(70, "refade_all");

        // Asynchronous reset between edges with all LEDs on.
        @(negedge CLK_BASE);
        #1;
        RESET_N = 1'b0;
        #1;
        e.cyc  = -1;
        e.exp  = 10'b0;
        e.name = "async_reset";
        sb.push_back(e);
        -> async_ev;
        MSS_READY = 1'b0;
        repeat (3) begin
            tick();
            expect_now(8'h00, 1'b0, 1'b0, "held_in_reset");
        end
        c0 = cyc;
        RESET_N = 1'b1;
        repeat (30) begin
            tick();
            expect_now(8'h00, 1'b0, 1'b0, "post_reset_wait");
        end

        repeat (2) tick();
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: %0d expectations left unchecked, required 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
